// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length encoder.
// A pair means: 'run' zeros, then one coefficient equal to 'value'.
package rle_pkg;

    localparam int WIDTH = 11;
    localparam int RUN_W = 6;
    localparam int CNT_W = 8;

    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [RUN_W-1:0]        run;
        logic signed [WIDTH-1:0] value;
        logic                    eob;
    } rle_pair_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rle_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rle_encoder_if.sv
// Coefficient input stream, pair output stream and per-block statistics.
// The encoder sits on the slave side; the producer/consumer on the master side.
interface rle_encoder_if;
    import rle_pkg::*;

    logic signed [WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;

    logic [RUN_W-1:0]        out_run;
    logic signed [WIDTH-1:0] out_value;
    logic                    out_eob;
    logic                    out_valid;
    logic                    out_ready;

    logic [CNT_W-1:0]        blk_pairs;
    logic                    blk_done;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_run, out_value, out_eob, out_valid, blk_pairs, blk_done
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_run, out_value, out_eob, out_valid, blk_pairs, blk_done
    );

endinterface

// File: rtl/rle_pair_reg.sv
// Single-entry valid/ready output register for encoded pairs.
//   state   | meaning
//   ST_IDLE | no pair held, out_valid=0
//   ST_HOLD | pair held, waiting on ready_i
module rle_pair_reg
    import rle_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  logic      ready_i,
    input  rle_pair_t pair_i,
    output logic      valid_o,
    output rle_pair_t pair_o
);

    rle_state_t state_q;
    rle_pair_t  pair_q;

    // load_i is only asserted when the register can take a pair (idle or draining).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pair_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        pair_q  <= pair_i;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ready_i) begin
                        if (load_i) pair_q <= pair_i;
                        else        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign valid_o = (state_q == ST_HOLD);
    assign pair_o  = pair_q;

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: zero-run counter, emit decision and per-block pair count.
// Pairs leave through rle_pair_reg with full-throughput valid/ready.
module rle_encoder
    import rle_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    rle_encoder_if.slave  bus
);

    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] blk_pairs_q, blk_pairs_d;
    logic             blk_done_q, blk_done_d;
    logic             accept, emit, out_valid;
    rle_pair_t        pair_d, pair_q;

    assign bus.in_ready = !out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Every emitted pair carries in_last as eob; an escape only fires when in_last=0.
    always_comb begin
        pair_d.run   = run_q;
        pair_d.value = bus.in_data;
        pair_d.eob   = bus.in_last;
        emit         = accept && ((bus.in_data != '0) || bus.in_last || (run_q == RUN_MAX));
        run_d        = run_q;
        pcnt_d       = pcnt_q;
        blk_pairs_d  = blk_pairs_q;
        blk_done_d   = 1'b0;
        if (accept) run_d = emit ? '0 : run_q + RUN_W'(1);
        if (emit) begin
            if (bus.in_last) begin
                blk_pairs_d = sat_inc(pcnt_q);
                blk_done_d  = 1'b1;
                pcnt_d      = '0;
            end else begin
                pcnt_d      = sat_inc(pcnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= '0;
            pcnt_q      <= '0;
            blk_pairs_q <= '0;
            blk_done_q  <= 1'b0;
        end else begin
            run_q       <= run_d;
            pcnt_q      <= pcnt_d;
            blk_pairs_q <= blk_pairs_d;
            blk_done_q  <= blk_done_d;
        end
    end

    rle_pair_reg u_pair_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (emit),
        .ready_i (bus.out_ready),
        .pair_i  (pair_d),
        .valid_o (out_valid),
        .pair_o  (pair_q)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_run   = pair_q.run;
    assign bus.out_value = pair_q.value;
    assign bus.out_eob   = pair_q.eob;
    assign bus.blk_pairs = blk_pairs_q;
    assign bus.blk_done  = blk_done_q;

endmodule

// File: tb/tb_rle_encoder.sv
// Scoreboard bench for rle_encoder: expected pairs and block counts are queued
// on each accepted coefficient and compared when the encoder hands them over.
module tb_rle_encoder;
    import rle_pkg::*;

    localparam int M_RUN_MAX = (1 << RUN_W) - 1;
    localparam int M_CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    rle_encoder_if bus();

    rle_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    rle_pair_t exp_q[$];
    int        blk_q[$];
    int        mrun  = 0;
    int        mpcnt = 0;
    bit        rand_ready = 0;
    bit        prev_stall = 0;
    rle_pair_t prev_pair;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(input logic signed [WIDTH-1:0] d, input logic l);
        rle_pair_t p;
        if (d != 0 || l || mrun == M_RUN_MAX) begin
            p.run = RUN_W'(mrun); p.value = d; p.eob = l;
            exp_q.push_back(p);
            if (l) begin
                blk_q.push_back((mpcnt == M_CNT_MAX) ? mpcnt : mpcnt + 1);
                mpcnt = 0;
            end else if (mpcnt != M_CNT_MAX) begin
                mpcnt++;
            end
            mrun = 0;
        end else begin
            mrun++;
        end
    endtask

    task automatic send(input logic signed [WIDTH-1:0] d, input logic l, output int waits);
        bus.in_data = d; bus.in_last = l; bus.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 500) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            $fatal(1, "input never accepted");
        end
        @(posedge clk);
        model_accept(d, l);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain_timeout", exp_q.size(), 0);
        #1;
    endtask

    always @(posedge clk) if (rand_ready) #1 bus.out_ready = ($urandom_range(0, 3) != 0);

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_pair", 1, 0);
                else begin
                    rle_pair_t e;
                    e = exp_q.pop_front();
                    check_eq("pair_run", bus.out_run, e.run);
                    check_eq("pair_value", bus.out_value, e.value);
                    check_eq("pair_eob", bus.out_eob, e.eob);
                end
            end
            if (bus.blk_done) begin
                check_eq("blk_done_with_eob", {bus.out_valid, bus.out_eob}, 2'b11);
                if (blk_q.size() == 0) check_eq("unexpected_blk_done", 1, 0);
                else check_eq("blk_pairs", bus.blk_pairs, blk_q.pop_front());
            end
            if (prev_stall)
                check_eq("hold_stable", {bus.out_valid, bus.out_run, bus.out_value, bus.out_eob},
                         {1'b1, prev_pair.run, prev_pair.value, prev_pair.eob});
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_pair.run = bus.out_run; prev_pair.value = bus.out_value; prev_pair.eob = bus.out_eob;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_fields"}, {bus.out_run, bus.out_value, bus.out_eob}, 0);
        check_eq({tag, "_blk"}, {bus.blk_pairs, bus.blk_done}, 0);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        int w;
        logic signed [WIDTH-1:0] v;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Block 5, 0, 0, -3, 0(last)
        send(11'sd5, 0, w); send(0, 0, w); send(0, 0, w); send(-11'sd3, 0, w); send(0, 1, w);
        drain();

        // 130 zeros then 7(last): two escapes then (2,7,1)
        for (int i = 0; i < 130; i++) send(0, 0, w);
        send(11'sd7, 1, w);
        drain();

        // Lone zero with last
        send(0, 1, w);
        drain();

        // Stall with a pair pending
        bus.out_ready = 1'b0;
        send(11'sd9, 0, w);
        bus.in_data = 11'sd8; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", bus.in_ready, 0);
            check_eq("stall_value", {bus.out_valid, bus.out_value}, {1'b1, 11'sd9});
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        send(11'sd8, 1, w);
        check_eq("release_no_wait", w, 0);
        @(negedge clk);
        check_eq("release_no_bubble", {bus.out_valid, bus.out_value}, {1'b1, 11'sd8});
        @(posedge clk); #1;
        drain();

        // Back-to-back nonzero, including -1 and the most negative value
        for (int i = 0; i < 8; i++) begin
            v = (i == 6) ? -11'sd1 : (i == 7) ? -11'sd1024 : 11'((i + 1) * ((i % 2) ? -1 : 1));
            send(v, i == 7, w);
            check_eq("b2b_no_wait", w, 0);
        end
        drain();

        // Reset mid-block after 10 zeros
        for (int i = 0; i < 10; i++) send(0, 0, w);
        #2 rst_n = 1'b0;
        mrun = 0; mpcnt = 0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        send(11'sd4, 1, w);
        drain();

        // Pair count saturation
        for (int i = 0; i < 300; i++) send(11'sd1, 0, w);
        send(11'sd1, 1, w);
        drain();

        // Random stream under random backpressure
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) v = 11'($urandom_range(1, 2047));
            else v = '0;
            send(v, $urandom_range(0, 40) == 0, w);
        end
        send(11'sd3, 1, w);
        rand_ready = 0;
        @(posedge clk); #2 bus.out_ready = 1'b1;
        drain();
        repeat (2) @(negedge clk);

        check_eq("leftover_pairs", exp_q.size(), 0);
        check_eq("leftover_blocks", blk_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
